// File: rtl/nibble_frame_display_pkg.sv
// Shared constants and types for the nibble frame display stage and its glyph decoder.
package nibble_frame_display_pkg;

  localparam int NBITS_NIB = 4;

  typedef enum logic [0:0] {
    DISP_EMPTY = 1'b0,
    DISP_SHOW  = 1'b1
  } disp_state_e;

  localparam logic [6:0] SEG_DASH = 7'h40;

  // Entry n is the g..a segment pattern for hex digit n.
  localparam logic [15:0][6:0] HEX_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic nib_parity(input logic [3:0] nib);
    return ^nib;
  endfunction

endpackage

// File: rtl/nibble_frame_display_if.sv
// Bundle of upstream register strobes/contents and the display-side results.
interface nibble_frame_display_if;
  logic       src_clear_n;
  logic       load_en;
  logic       shift_en;
  logic [3:0] nibble_in;
  logic [7:0] seg;
  logic       frame_valid;
  logic [2:0] frame_cnt;
  logic [1:0] bit_cnt;

  modport master (
    output src_clear_n, load_en, shift_en, nibble_in,
    input  seg, frame_valid, frame_cnt, bit_cnt
  );

  modport slave (
    input  src_clear_n, load_en, shift_en, nibble_in,
    output seg, frame_valid, frame_cnt, bit_cnt
  );
endinterface

// File: rtl/nibble_frame_display_hex7seg_decode.sv
// Combinational 4-bit to 7-segment (g..a) hex glyph lookup.
module hex7seg_decode
  import nibble_frame_display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] glyph_o
);

  // Table lookup of the glyph for the incoming digit
  always_comb begin
    glyph_o = HEX_GLYPHS[nib_i];
  end

endmodule

// File: rtl/nibble_frame_display.sv
// Counts upstream shifts/loads, captures each completed nibble and shows it on a 7-segment display.
// Optional build macro SEG_DP_PARITY_EN drives the decimal point with the held nibble's parity.
module nibble_frame_display #(
  parameter int SHIFTS_PER_FRAME = 4,
  parameter int NBITS_NIB        = nibble_frame_display_pkg::NBITS_NIB
) (
  input logic                   clk_2,
  input logic                   reset,
  nibble_frame_display_if.slave bus
);
  import nibble_frame_display_pkg::*;

  localparam logic [1:0] LAST_SHIFT = 2'(SHIFTS_PER_FRAME - 1);

  logic [1:0]           bit_cnt_q;
  logic [1:0]           bit_cnt_d;
  logic                 pending_q;
  logic                 pending_d;
  logic [NBITS_NIB-1:0] held_q;
  logic                 frame_valid_q;
  logic [2:0]           frame_cnt_q;
  disp_state_e          state_q;
  logic [6:0]           glyph_s;
  logic [7:0]           seg_s;

  // Event stage: clear beats load, load beats shift
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    pending_d = 1'b0;
    if (!bus.src_clear_n) begin
      bit_cnt_d = 2'd0;
      pending_d = 1'b0;
    end else if (bus.load_en) begin
      bit_cnt_d = 2'd0;
      pending_d = 1'b1;
    end else if (bus.shift_en) begin
      if (bit_cnt_q == LAST_SHIFT) begin
        bit_cnt_d = 2'd0;
        pending_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 2'd1;
        pending_d = 1'b0;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
      pending_d = 1'b0;
    end
  end

  // Event stage registers
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= 2'd0;
      pending_q <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      pending_q <= pending_d;
    end
  end

  // Capture stage and display FSM; a clear in the pending cycle still captures the pre-clear contents
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      held_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= 3'd0;
      state_q       <= DISP_EMPTY;
    end else begin
      frame_valid_q <= pending_q;
      if (pending_q) begin
        held_q      <= bus.nibble_in;
        frame_cnt_q <= frame_cnt_q + 3'd1;
        case (state_q)
          DISP_EMPTY: state_q <= DISP_SHOW;
          DISP_SHOW:  state_q <= DISP_SHOW;
          default:    state_q <= DISP_SHOW;
        endcase
      end
    end
  end

  hex7seg_decode u_hex7seg_decode (
    .nib_i   (held_q),
    .glyph_o (glyph_s)
  );

  // Segment output: dash until the first capture, then the held glyph
  always_comb begin
    seg_s = {1'b0, SEG_DASH};
    if (state_q == DISP_SHOW) begin
      seg_s[6:0] = glyph_s;
`ifdef SEG_DP_PARITY_EN
      seg_s[7]   = nib_parity(held_q);
`else
      seg_s[7]   = 1'b0;
`endif
    end else begin
      seg_s = {1'b0, SEG_DASH};
    end
  end

  assign bus.seg         = seg_s;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_nibble_frame_display.sv
// Directed bench for nibble_frame_display: a spec-level model of the upstream register and
// the frame/display rules, compared against the DUT on every falling edge.
module tb_nibble_frame_display;

  localparam int SPF = 4;

  logic clk_2 = 1'b0;
  logic reset = 1'b1;

  nibble_frame_display_if bus();

  nibble_frame_display #(.SHIFTS_PER_FRAME(SPF), .NBITS_NIB(4)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2 = ~clk_2;

  int checks = 0;
  int errors = 0;
  int fv_count = 0;

  // literal-check request from the driver, consumed by the compare process
  int    lit_sel = 0;
  int    lit_exp = 0;
  string lit_name = "";

  // upstream register and spec-level model state
  logic [3:0] up_reg = 4'h0;
  int m_shifts, m_held, m_frames;
  bit m_capture_next, m_shown, m_fv;

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] model_seg();
    logic [3:0] h;
    logic       dp;
    h  = 4'(m_held);
    dp = 1'b0;
`ifdef SEG_DP_PARITY_EN
    dp = h[0] ^ h[1] ^ h[2] ^ h[3];
`endif
    if (!m_shown) return 8'h40;
    return {dp, glyph(m_held)};
  endfunction

  task automatic model_reset();
    m_shifts = 0; m_held = 0; m_frames = 0;
    m_capture_next = 0; m_shown = 0; m_fv = 0;
  endtask

  // One clock edge of the model, using the inputs currently driven
  task automatic model_edge();
    m_fv = m_capture_next;
    if (m_capture_next) begin
      m_held   = int'(bus.nibble_in);
      m_frames = m_frames + 1;
      m_shown  = 1;
    end
    if (!bus.src_clear_n) begin
      m_shifts = 0; m_capture_next = 0;
    end else if (bus.load_en) begin
      m_shifts = 0; m_capture_next = 1;
    end else if (bus.shift_en) begin
      m_shifts = m_shifts + 1;
      m_capture_next = (m_shifts == SPF);
      if (m_shifts == SPF) m_shifts = 0;
    end else begin
      m_capture_next = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, plus any pending literal expectation
  always @(negedge clk_2) begin
    chk("seg", int'(bus.seg), int'(model_seg()));
    chk("frame_valid", int'(bus.frame_valid), int'(m_fv));
    chk("frame_cnt", int'(bus.frame_cnt), m_frames % 8);
    chk("bit_cnt", int'(bus.bit_cnt), m_shifts);
    if (bus.frame_valid) fv_count++;
    case (lit_sel)
      1: chk(lit_name, int'(bus.seg), lit_exp);
      2: chk(lit_name, int'(bus.frame_cnt), lit_exp);
      3: chk(lit_name, int'(bus.bit_cnt), lit_exp);
      4: chk(lit_name, fv_count, lit_exp);
      default: ;
    endcase
  end

  task automatic expect_lit(input int sel, input int exp, input string name);
    lit_sel = sel; lit_exp = exp; lit_name = name;
  endtask

  // Drive one cycle at the falling edge; returns right after the following rising edge
  task automatic step(input bit clr_n, input bit ld, input bit sh, input bit sbit, input logic [3:0] data);
    @(negedge clk_2);
    bus.src_clear_n = clr_n;
    bus.load_en     = ld;
    bus.shift_en    = sh;
    bus.nibble_in   = up_reg;
    @(posedge clk_2);
    lit_sel = 0;
    model_edge();
    if (!clr_n)   up_reg = 4'h0;
    else if (ld)  up_reg = data;
    else if (sh)  up_reg = {sbit, up_reg[3:1]};
    else          up_reg = up_reg;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  // Reset pulse in the middle of a cycle; checked at the falling edge while reset is high
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    bus.src_clear_n = 1'b1; bus.load_en = 1'b0; bus.shift_en = 1'b0;
    expect_lit(1, 8'h40, "seg_after_reset");
    #6;
    reset = 1'b0;
    @(posedge clk_2);
    lit_sel = 0;
    model_edge();
  endtask

  int mark;
  logic [3:0] bits_a [4];

  initial begin
    bus.src_clear_n = 1'b1; bus.load_en = 1'b0; bus.shift_en = 1'b0; bus.nibble_in = 4'h0;
    model_reset();
    @(posedge clk_2);
    @(posedge clk_2);
    #2 reset = 1'b0;

    // idle after reset
    mark = fv_count;
    for (int i = 0; i < 10; i++) idle();
    expect_lit(2, 0, "idle_frame_cnt");
    idle();
    expect_lit(4, mark, "idle_no_frame_valid");

    // serial 1,0,1,1 entering at the MSB -> 4'b1101
    bits_a = '{4'd1, 4'd0, 4'd1, 4'd1};
    mark = fv_count;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, bits_a[i][0], 4'h0);
    idle();
`ifdef SEG_DP_PARITY_EN
    expect_lit(1, 8'hDE, "serial_seg");
`else
    expect_lit(1, 8'h5E, "serial_seg");
`endif
    idle();
    expect_lit(2, 1, "serial_frame_cnt");
    idle();
    expect_lit(4, mark + 1, "serial_one_pulse");

    // parallel load of 5
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h5);
    idle();
    expect_lit(1, 8'h6D, "load_seg");
    idle();
    expect_lit(3, 0, "load_bit_cnt");

    // partial frame discarded by clear, then a full frame of zeros
    mark = fv_count;
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'h0);
    expect_lit(3, 2, "partial_bit_cnt");
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    idle();
    expect_lit(1, 8'h3F, "clear_seg");
    idle();
    expect_lit(4, mark + 1, "clear_one_pulse");

    // nine back-to-back loads from a fresh count
    do_reset();
    idle();
    mark = fv_count;
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'(i + 3));
    idle();
    expect_lit(2, 1, "nine_loads_frame_cnt");
    idle();
    expect_lit(4, mark + 9, "nine_loads_pulses");

    // reset mid-frame, then a fresh frame
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 4'h0);
    expect_lit(3, 3, "pre_reset_bit_cnt");
    idle();
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'h0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'(i), 4'h0);
    idle();
    expect_lit(2, 1, "post_reset_frame_cnt");
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
